// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access stage with MEM/WB pipeline register
//
// Purpose:
//   Takes the EX/MEM slot and either passes an ALU result straight into the
//   MEM/WB register, or runs a load/store on a wait-stated req/ack data bus.
//   While an access is outstanding the upstream pipeline is held via
//   MEM_STALL. An access that waits TIMEOUT cycles without dm_ack is aborted,
//   squashed in WB and flagged on the sticky ERR output.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   MEM_VALID         EX/MEM slot holds a real instruction
//   MEM_DM_WE         store request
//   MEM_RF_D_SEL      1 = write back memory data (load), 0 = ALU result
//   MEM_ALU_RES       ALU result
//   MEM_muxB          store data
//   MEM_DM_ADDR       data-memory address
//   MEM_RF_WE         instruction writes the register file
//   MEM_RF_WA         destination register
//   MEM_STALL         hold EX/MEM and earlier stages (combinational)
//   dm_req            memory request (registered)
//   dm_we             1 = write, 0 = read
//   dm_addr           latched address
//   dm_wdata          latched store data
//   dm_ack            memory completes the access this cycle
//   dm_rdata          read data, valid with dm_ack
//   WB_VALID          WB slot valid
//   WB_RF_WE          register-file write enable
//   WB_RF_WA          destination register
//   WB_RF_D           write-back data
//   ERR               sticky timeout flag

module mem_wb_stage #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int RA_W    = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_VALID,
  input  logic              MEM_DM_WE,
  input  logic              MEM_RF_D_SEL,
  input  logic [DATA_W-1:0] MEM_ALU_RES,
  input  logic [DATA_W-1:0] MEM_muxB,
  input  logic [ADDR_W-1:0] MEM_DM_ADDR,
  input  logic              MEM_RF_WE,
  input  logic [RA_W-1:0]   MEM_RF_WA,
  output logic              MEM_STALL,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              WB_VALID,
  output logic              WB_RF_WE,
  output logic [RA_W-1:0]   WB_RF_WA,
  output logic [DATA_W-1:0] WB_RF_D,
  output logic              ERR
);

  // The counter holds the number of ack-less WAIT cycles already completed,
  // so the abort fires in the TIMEOUT-th WAIT cycle when cnt == TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          state;
  logic [7:0]      cnt;
  logic            lat_rf_we;
  logic            lat_store;
  logic [RA_W-1:0] lat_wa;

  logic store;
  logic load;
  logic access;
  logic at_limit;

  always_comb begin
    store    = MEM_VALID & MEM_DM_WE;
    load     = MEM_VALID & MEM_RF_D_SEL & ~MEM_DM_WE;
    access   = store | load;
    at_limit = (cnt == CNT_LAST);
    MEM_STALL = 1'b0;
    if (state == S_IDLE) begin
      MEM_STALL = access;
    end else begin
      // Upstream advances on the completing edge, and also on the abort edge.
      MEM_STALL = ~dm_ack & ~at_limit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      lat_rf_we <= 1'b0;
      lat_store <= 1'b0;
      lat_wa    <= '0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      WB_VALID  <= 1'b0;
      WB_RF_WE  <= 1'b0;
      WB_RF_WA  <= '0;
      WB_RF_D   <= '0;
      ERR       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            // Freeze the bus request and the WB bookkeeping for the access.
            dm_req    <= 1'b1;
            dm_we     <= store;
            dm_addr   <= MEM_DM_ADDR;
            dm_wdata  <= MEM_muxB;
            lat_wa    <= MEM_RF_WA;
            lat_rf_we <= MEM_RF_WE;
            lat_store <= store;
            cnt       <= 8'd0;
            WB_VALID  <= 1'b0;
            WB_RF_WE  <= 1'b0;
            state     <= S_WAIT;
          end else begin
            WB_VALID <= MEM_VALID;
            WB_RF_WE <= MEM_VALID & MEM_RF_WE;
            WB_RF_WA <= MEM_RF_WA;
            WB_RF_D  <= MEM_ALU_RES;
          end
        end

        S_WAIT: begin
          if (dm_ack) begin
            // An ack in the limit cycle still wins over the timeout.
            dm_req   <= 1'b0;
            cnt      <= 8'd0;
            state    <= S_IDLE;
            WB_VALID <= 1'b1;
            WB_RF_WA <= lat_wa;
            if (lat_store) begin
              WB_RF_WE <= 1'b0;
              WB_RF_D  <= '0;
            end else begin
              WB_RF_WE <= lat_rf_we;
              WB_RF_D  <= dm_rdata;
            end
          end else if (at_limit) begin
            // Abort: retire the instruction as a squashed slot.
            dm_req   <= 1'b0;
            cnt      <= 8'd0;
            state    <= S_IDLE;
            ERR      <= 1'b1;
            WB_VALID <= 1'b1;
            WB_RF_WE <= 1'b0;
            WB_RF_WA <= lat_wa;
            WB_RF_D  <= '0;
          end else begin
            cnt      <= cnt + 8'd1;
            WB_VALID <= 1'b0;
            WB_RF_WE <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage

module tb_mem_wb_stage;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int RA_W    = 5;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              MEM_VALID, MEM_DM_WE, MEM_RF_D_SEL, MEM_RF_WE;
  logic [DATA_W-1:0] MEM_ALU_RES, MEM_muxB;
  logic [ADDR_W-1:0] MEM_DM_ADDR;
  logic [RA_W-1:0]   MEM_RF_WA;
  logic              MEM_STALL;
  logic              dm_req, dm_we, dm_ack;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic              WB_VALID, WB_RF_WE, ERR;
  logic [RA_W-1:0]   WB_RF_WA;
  logic [DATA_W-1:0] WB_RF_D;

  int checks   = 0;
  int failures = 0;
  logic err_model = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RA_W(RA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_VALID(MEM_VALID), .MEM_DM_WE(MEM_DM_WE), .MEM_RF_D_SEL(MEM_RF_D_SEL),
    .MEM_ALU_RES(MEM_ALU_RES), .MEM_muxB(MEM_muxB), .MEM_DM_ADDR(MEM_DM_ADDR),
    .MEM_RF_WE(MEM_RF_WE), .MEM_RF_WA(MEM_RF_WA), .MEM_STALL(MEM_STALL),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .WB_VALID(WB_VALID), .WB_RF_WE(WB_RF_WE), .WB_RF_WA(WB_RF_WA),
    .WB_RF_D(WB_RF_D), .ERR(ERR)
  );

  typedef struct {
    logic        valid, dm_we, d_sel, rf_we;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic        e_valid, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_d;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic scramble();
    MEM_VALID    = 1'($urandom);
    MEM_DM_WE    = 1'($urandom);
    MEM_RF_D_SEL = 1'($urandom);
    MEM_RF_WE    = 1'($urandom);
    MEM_RF_WA    = 5'($urandom);
    MEM_ALU_RES  = $urandom;
    MEM_muxB     = $urandom;
    MEM_DM_ADDR  = 16'($urandom);
  endtask

  task automatic idle_inputs();
    MEM_VALID = 0; MEM_DM_WE = 0; MEM_RF_D_SEL = 0; MEM_RF_WE = 0;
    MEM_RF_WA = 0; MEM_ALU_RES = 0; MEM_muxB = 0; MEM_DM_ADDR = 0;
  endtask

  // Non-access slot: one cycle, never stalls, caller supplies the expectation.
  task automatic do_plain(input logic valid, input logic dm_we_i, input logic d_sel,
                          input logic rf_we, input logic [4:0] wa, input logic [31:0] alu,
                          input logic e_valid, input logic e_we, input logic [4:0] e_wa,
                          input logic [31:0] e_d);
    MEM_VALID = valid; MEM_DM_WE = dm_we_i; MEM_RF_D_SEL = d_sel; MEM_RF_WE = rf_we;
    MEM_RF_WA = wa; MEM_ALU_RES = alu; MEM_muxB = $urandom; MEM_DM_ADDR = 16'($urandom);
    dm_ack = 0;
    #1;
    chk("plain_stall", 32'(MEM_STALL), 32'(0));
    @(posedge clk); #1;
    chk("plain_wb_valid", 32'(WB_VALID), 32'(e_valid));
    chk("plain_wb_we", 32'(WB_RF_WE), 32'(e_we));
    chk("plain_wb_wa", 32'(WB_RF_WA), 32'(e_wa));
    chk("plain_wb_d", 32'(WB_RF_D), e_d);
    chk("plain_dm_req", 32'(dm_req), 32'(0));
    chk("plain_err", 32'(ERR), 32'(err_model));
  endtask

  // Load/store transaction. ack_at = WAIT cycle carrying dm_ack (> TIMEOUT: never).
  task automatic do_access(input logic is_store, input logic d_sel, input logic rf_we,
                           input logic [4:0] wa, input logic [15:0] addr,
                           input logic [31:0] wdata, input int ack_at,
                           input logic [31:0] rdata,
                           output int req_cycles, output int stall_cycles);
    int k;
    logic ok;
    req_cycles = 0;
    stall_cycles = 0;
    MEM_VALID = 1; MEM_DM_WE = is_store; MEM_RF_D_SEL = is_store ? d_sel : 1'b1;
    MEM_RF_WE = rf_we; MEM_RF_WA = wa; MEM_DM_ADDR = addr; MEM_muxB = wdata;
    MEM_ALU_RES = $urandom; dm_ack = 0;
    #1;
    chk("decode_stall", 32'(MEM_STALL), 32'(1));
    if (MEM_STALL) stall_cycles++;
    @(posedge clk); #1;
    chk("issue_wb_valid", 32'(WB_VALID), 32'(0));
    k = 0;
    ok = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      k = c;
      scramble();
      dm_ack = (c == ack_at);
      dm_rdata = dm_ack ? rdata : $urandom;
      #1;
      chk("wait_stall", 32'(MEM_STALL), 32'((c != ack_at) && (c != TIMEOUT)));
      if (MEM_STALL) stall_cycles++;
      chk("wait_req", 32'(dm_req), 32'(1));
      if (dm_req) req_cycles++;
      chk("wait_dm_we", 32'(dm_we), 32'(is_store));
      chk("wait_dm_addr", 32'(dm_addr), 32'(addr));
      if (is_store) chk("wait_dm_wdata", dm_wdata, wdata);
      @(posedge clk); #1;
      dm_ack = 0;
      if (c == ack_at) begin
        ok = 1'b1;
        break;
      end
      if (c != TIMEOUT) chk("wait_wb_valid", 32'(WB_VALID), 32'(0));
    end
    if (!ok) err_model = 1'b1;
    chk("done_req", 32'(dm_req), 32'(0));
    chk("done_wb_valid", 32'(WB_VALID), 32'(1));
    chk("done_wb_wa", 32'(WB_RF_WA), 32'(wa));
    chk("done_wb_we", 32'(WB_RF_WE), 32'(ok && !is_store && rf_we));
    if (ok) chk("done_wb_d", WB_RF_D, is_store ? 32'h0 : rdata);
    chk("done_err", 32'(ERR), 32'(err_model));
    chk("done_cycles", 32'(k), 32'(ok ? ack_at : TIMEOUT));
  endtask

  initial begin
    int rq, st, ack_at, op;
    logic [31:0] rd, wd;
    logic [4:0] wa;
    logic v, we;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  32'h12345678, 1'b1, 1'b1, 5'd3,  32'h12345678};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 1'b0, 5'd7,  32'hA5A5A5A5};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd31, 32'hFFFFFFFF};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h00000000, 1'b1, 1'b0, 5'd0,  32'h00000000};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 32'h00000001, 1'b0, 1'b0, 5'd12, 32'h00000001};

    idle_inputs();
    dm_ack = 0; dm_rdata = 0;
    rst_n = 0;
    #12;
    chk("rst_dm_req", 32'(dm_req), 32'(0));
    chk("rst_dm_we", 32'(dm_we), 32'(0));
    chk("rst_dm_addr", 32'(dm_addr), 32'(0));
    chk("rst_dm_wdata", dm_wdata, 32'(0));
    chk("rst_wb_valid", 32'(WB_VALID), 32'(0));
    chk("rst_wb_we", 32'(WB_RF_WE), 32'(0));
    chk("rst_wb_wa", 32'(WB_RF_WA), 32'(0));
    chk("rst_wb_d", WB_RF_D, 32'(0));
    chk("rst_err", 32'(ERR), 32'(0));
    chk("rst_stall", 32'(MEM_STALL), 32'(0));
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      do_plain(tbl[i].valid, tbl[i].dm_we, tbl[i].d_sel, tbl[i].rf_we, tbl[i].wa,
               tbl[i].alu, tbl[i].e_valid, tbl[i].e_we, tbl[i].e_wa, tbl[i].e_d);

    // Load, ack in the 4th WAIT cycle.
    do_access(1'b0, 1'b1, 1'b1, 5'd9, 16'h0040, 32'h0, 4, 32'hDEADBEEF, rq, st);
    chk("load_req_cycles", 32'(rq), 32'(4));
    chk("load_stall_cycles", 32'(st), 32'(4));
    // Store, ack in the first WAIT cycle.
    do_access(1'b1, 1'b0, 1'b1, 5'd4, 16'h0100, 32'hCAFEF00D, 1, 32'h0, rq, st);
    chk("store_req_cycles", 32'(rq), 32'(1));
    chk("store_stall_cycles", 32'(st), 32'(1));
    // Both selects set: store wins.
    do_access(1'b1, 1'b1, 1'b1, 5'd5, 16'h0200, 32'h01020304, 2, 32'h0, rq, st);
    // Ack in the limit cycle completes normally.
    do_access(1'b0, 1'b1, 1'b1, 5'd6, 16'h0300, 32'h0, TIMEOUT, 32'h55AA55AA, rq, st);
    chk("limit_err", 32'(ERR), 32'(0));
    // Timeout, then a normal ALU op.
    do_access(1'b0, 1'b1, 1'b1, 5'd8, 16'h0400, 32'h0, TIMEOUT + 1, 32'h0, rq, st);
    chk("timeout_req_cycles", 32'(rq), 32'(TIMEOUT));
    chk("timeout_err", 32'(ERR), 32'(1));
    do_plain(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h12345678, 1'b1, 1'b1, 5'd3, 32'h12345678);
    chk("timeout_err_sticky", 32'(ERR), 32'(1));

    // Reset in the middle of WAIT.
    MEM_VALID = 1; MEM_DM_WE = 0; MEM_RF_D_SEL = 1; MEM_RF_WE = 1;
    MEM_RF_WA = 5'd17; MEM_DM_ADDR = 16'h0500;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #3;
    chk("pre_rst_req", 32'(dm_req), 32'(1));
    rst_n = 0;
    #1;
    chk("midrst_req", 32'(dm_req), 32'(0));
    chk("midrst_wb_valid", 32'(WB_VALID), 32'(0));
    chk("midrst_wb_we", 32'(WB_RF_WE), 32'(0));
    chk("midrst_wb_wa", 32'(WB_RF_WA), 32'(0));
    chk("midrst_wb_d", WB_RF_D, 32'(0));
    chk("midrst_err", 32'(ERR), 32'(0));
    err_model = 1'b0;
    #2;
    rst_n = 1;
    @(posedge clk); #1;
    chk("postrst_req", 32'(dm_req), 32'(0));
    do_access(1'b0, 1'b1, 1'b1, 5'd17, 16'h0500, 32'h0, 2, 32'h0BADF00D, rq, st);

    // Randomized transactions against the transaction-level model above.
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 3);
      wa = 5'($urandom);
      v  = 1'($urandom);
      we = 1'($urandom);
      rd = $urandom;
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) ack_at = $urandom_range(1, TIMEOUT + 1);
      else ack_at = $urandom_range(1, 4);
      case (op)
        0: do_plain(1'b1, 1'b0, 1'b0, we, wa, wd, 1'b1, we, wa, wd);
        1: do_plain(1'b0, 1'($urandom), 1'($urandom), we, wa, wd, 1'b0, 1'b0, wa, wd);
        2: do_access(1'b0, 1'b1, we, wa, 16'($urandom), wd, ack_at, rd, rq, st);
        default: do_access(1'b1, v, we, wa, 16'($urandom), wd, ack_at, rd, rq, st);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register. Consumes the EX/MEM outputs, performs the load or store on a wait-stated data-memory bus with a req/ack handshake, and stalls the upstream pipeline while the access is outstanding. Presents registered write-back results (register-file data, write enable, destination) to the WB stage.

Parameters:
ADDR_W, 16, data-memory address width
DATA_W, 32, data word width
RA_W, 5, register-file destination address width
TIMEOUT, 15, maximum WAIT cycles without dm_ack before the access is aborted (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
MEM_VALID  in  1  EX/MEM slot holds a real instruction
MEM_DM_WE  in  1  store request
MEM_RF_D_SEL  in  1  1 = write back memory data (load), 0 = write back ALU result
MEM_ALU_RES  in  DATA_W  ALU result
MEM_muxB  in  DATA_W  store data
MEM_DM_ADDR  in  ADDR_W  data-memory address
MEM_RF_WE  in  1  instruction writes the register file
MEM_RF_WA  in  RA_W  destination register
MEM_STALL  out  1  hold EX/MEM and earlier stages this cycle
dm_req  out  1  memory request, registered
dm_we  out  1  1 = write, 0 = read
dm_addr  out  ADDR_W  latched address
dm_wdata  out  DATA_W  latched store data
dm_ack  in  1  memory completes the access this cycle
dm_rdata  in  DATA_W  read data, valid when dm_ack=1
WB_VALID  out  1  WB slot valid
WB_RF_WE  out  1  register-file write enable
WB_RF_WA  out  RA_W  destination register
WB_RF_D  out  DATA_W  write-back data
ERR  out  1  sticky timeout flag

Behaviour:
- Reset, asynchronous: state IDLE, timeout counter 0. dm_req, dm_we, dm_addr, dm_wdata, WB_VALID, WB_RF_WE, WB_RF_WA, WB_RF_D and ERR all go to 0. A reset during WAIT drops dm_req immediately and discards the access.
- Decode in IDLE:
  - store = MEM_VALID & MEM_DM_WE.
  - load = MEM_VALID & MEM_RF_D_SEL & !MEM_DM_WE. Store has priority when both selects are set.
  - access = store | load.
- IDLE, no access: at the clock edge the WB registers load WB_VALID=MEM_VALID, WB_RF_WE=MEM_VALID&MEM_RF_WE, WB_RF_WA=MEM_RF_WA and WB_RF_D=MEM_ALU_RES. Latency is 1 cycle and MEM_STALL=0.
- IDLE, access:
  - MEM_STALL=1 combinationally.
  - At the edge, latch dm_addr, dm_wdata, dm_we=store, the destination register and a store flag; set dm_req=1 and move to WAIT.
  - WB_VALID=0 (bubble).
- WAIT:
  - dm_req stays high and all dm_* outputs stay stable.
  - MEM_STALL = !dm_ack. Upstream advances on the same edge that completes the access.
  - Each cycle with dm_ack=0, the counter increments and WB_VALID=0.
- WAIT with dm_ack=1, at the edge:
  - dm_req goes to 0, the counter clears and the state returns to IDLE.
  - WB_VALID=1.
  - Load: WB_RF_WE=latched MEM_RF_WE and WB_RF_D=dm_rdata.
  - Store: WB_RF_WE=0 and WB_RF_D=0.
- Back-to-back accesses: the next access sees IDLE one cycle later, so there is always one IDLE decode cycle between accesses. dm_req is low for at least one cycle between requests.
- Timeout: if the counter reaches TIMEOUT in WAIT with dm_ack=0, then at that edge:
  - dm_req goes to 0, ERR goes to 1 (sticky until reset) and the state returns to IDLE.
  - WB_VALID=1 with WB_RF_WE=0 (instruction squashed). MEM_STALL is 0 in that cycle.
  - A dm_ack arriving in the same cycle the counter hits TIMEOUT wins: the access completes normally and no ERR is set.
- Memory access latency: 2 cycles minimum (decode + ack-in-first-WAIT); total = 1 + wait cycles.
- MEM_STALL is combinational from state, decode and dm_ack. There are no other combinational input-to-output paths.

Test Plan:
- ALU op: MEM_VALID=1, RF_D_SEL=0, RF_WE=1, WA=3, ALU_RES=0x12345678 -> next cycle WB_VALID=1, WB_RF_WE=1, WB_RF_WA=3, WB_RF_D=0x12345678; MEM_STALL never 1.
- Load with 3 wait cycles: ADDR=0x0040, dm_ack high on the 4th WAIT cycle with rdata=0xDEADBEEF -> dm_req high for exactly 4 cycles, dm_we=0, dm_addr=0x0040; MEM_STALL high for 4 cycles; then WB_RF_D=0xDEADBEEF with WB_RF_WE=1.
- Store, ack in first WAIT cycle: muxB=0xCAFEF00D, ADDR=0x0100 -> dm_we=1, dm_wdata=0xCAFEF00D held while dm_req=1; result WB_VALID=1, WB_RF_WE=0; 2-cycle latency.
- Timeout, TIMEOUT=15, dm_ack never asserted -> after 15 WAIT cycles dm_req falls, ERR=1 and stays 1, squashed WB_VALID=1/WB_RF_WE=0 pulse; a following ALU op completes normally.
- Ack at the limit: dm_ack asserted in the same cycle the counter hits TIMEOUT -> normal completion, ERR stays 0.
- Reset mid-access: rst_n low during WAIT -> dm_req and all WB outputs drop to 0 immediately with no clock edge; after release the state is IDLE and the next load completes normally.
